// File: rtl/sample_interpolator.sv
// Linear upsampler: renders 2^LOG2_FACTOR fine samples between the previous coarse
// sample and each new one, emitting one fine sample per step strobe.
module sample_interpolator #(
    parameter int WIDTH       = 12,
    parameter int LOG2_FACTOR = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] incoming_sample,
    input  logic             step,
    output logic [WIDTH-1:0] modified_sample,
    output logic             sample_valid,
    output logic             busy,
    output logic             done
);

    localparam int ACC_W = WIDTH + LOG2_FACTOR + 1;
    localparam int K_W   = LOG2_FACTOR + 1;
    localparam logic [K_W-1:0] K_LAST = K_W'((1 << LOG2_FACTOR) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                    state_r;
    logic signed [WIDTH-1:0]   x0_r;
    logic signed [WIDTH-1:0]   x1_r;
    logic signed [WIDTH:0]     diff_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic [K_W-1:0]            k_r;

    logic signed [WIDTH:0]     diff_load_s;
    logic signed [ACC_W-1:0]   acc_load_s;
    logic signed [ACC_W-1:0]   acc_step_s;
    logic                      last_step_s;

    // Datapath: interval setup values and the next accumulator value.
    always_comb begin
        diff_load_s = (WIDTH+1)'(x1_r) - (WIDTH+1)'(x0_r);
        acc_load_s  = ACC_W'(x0_r) <<< LOG2_FACTOR;
        acc_step_s  = acc_r + ACC_W'(diff_r);
        last_step_s = (k_r == K_LAST);
    end

    // Control FSM with registered outputs; the fine sample is the accumulator's
    // integer part, which always fits WIDTH since it lies between X0 and X1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            x0_r            <= '0;
            x1_r            <= '0;
            diff_r          <= '0;
            acc_r           <= '0;
            k_r             <= '0;
            modified_sample <= '0;
            sample_valid    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x1_r    <= incoming_sample;
                        busy    <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    diff_r  <= diff_load_s;
                    acc_r   <= acc_load_s;
                    k_r     <= '0;
                    state_r <= RUN;
                end
                RUN: begin
                    if (step) begin
                        acc_r           <= acc_step_s;
                        k_r             <= k_r + K_W'(1);
                        modified_sample <= acc_step_s[LOG2_FACTOR +: WIDTH];
                        sample_valid    <= 1'b1;
                        if (last_step_s) begin
                            done    <= 1'b1;
                            x0_r    <= x1_r;
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_interpolator.sv
// Scoreboard bench for sample_interpolator: the stimulus process queues expected
// fine samples, a separate monitor checks each sample_valid pulse against the queue.
module tb_sample_interpolator;

    localparam int W = 12;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] incoming_sample = '0;
    logic         step = 1'b0;
    logic [W-1:0] modified_sample;
    logic         sample_valid;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int value;
        bit last;
    } exp_t;
    exp_t sb[$];

    sample_interpolator #(.WIDTH(W), .LOG2_FACTOR(3)) dut (
        .clock(clock), .reset(reset), .start(start),
        .incoming_sample(incoming_sample), .step(step),
        .modified_sample(modified_sample), .sample_valid(sample_valid),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Monitor: every valid pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && sample_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sample", int'($signed(modified_sample)), e.value);
                    check("done_with_sample", int'(done), int'(e.last));
                end
            end else if (reset && done) begin
                check("done_without_valid", 1, 0);
            end
        end
    end

    task automatic do_start(input int value, input bit with_step);
        @(posedge clock); #1;
        start = 1'b1;
        incoming_sample = W'(value);
        step = with_step;
        @(posedge clock); #1;
        start = 1'b0;
        step = 1'b0;
    endtask

    task automatic do_step();
        @(posedge clock); #1;
        step = 1'b1;
        @(posedge clock); #1;
        step = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic push(input int value, input bit last);
        exp_t e;
        e.value = value;
        e.last = last;
        sb.push_back(e);
    endtask

    // Full interval: queue 8 expected samples, start, step 8 times, check busy.
    task automatic interval(input string name, input int x1, input int exp_vals[8]);
        for (int i = 0; i < 8; i++) push(exp_vals[i], i == 7);
        do_start(x1, 1'b0);
        check({name, "_busy_rise"}, int'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            do_step();
            if (i == 6) check({name, "_busy_mid"}, int'(busy), 1);
        end
        check({name, "_busy_fall"}, int'(busy), 0);
        check({name, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        int v1[8]  = '{100, 200, 300, 400, 500, 600, 700, 800};
        int v2[8]  = '{600, 400, 200, 0, -200, -400, -600, -800};
        int v3a[8] = '{0, 1, 1, 2, 3, 3, 4, 5};
        int v3b[8] = '{-1, -2, -2, -3, -4, -4, -5, -5};
        int v4a[8] = '{251, 508, 764, 1021, 1277, 1534, 1790, 2047};
        int v4b[8] = '{1535, 1023, 511, -1, -513, -1025, -1537, -2048};
        int v6[8]  = '{10, 20, 30, 40, 50, 60, 70, 80};

        repeat (3) @(posedge clock);
        #1;
        check("reset_sample", int'(modified_sample), 0);
        check("reset_valid", int'(sample_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        interval("ramp_up", 800, v1);
        check("hold_after_interval", int'($signed(modified_sample)), 800);
        interval("ramp_down", -800, v2);

        // Rounding toward minus infinity, both signs.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        interval("round_pos", 5, v3a);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        interval("round_neg", -5, v3b);

        interval("to_max", 2047, v4a);
        interval("full_scale", -2048, v4b);

        // Protocol: start+step together, step in LOAD, start during RUN.
        for (int i = 0; i < 8; i++) push(-1792 + 256 * i, i == 7);
        do_start(0, 1'b1);
        step = 1'b1;
        @(posedge clock); #1;
        step = 1'b0;
        check("no_valid_after_load_step", int'(sample_valid), 0);
        for (int i = 0; i < 8; i++) begin
            do_step();
            if (i == 1) begin
                do_start(100, 1'b0);
                check("busy_after_ignored_start", int'(busy), 1);
            end
        end
        check("proto_busy_fall", int'(busy), 0);
        check("proto_drained", sb.size(), 0);
        check("proto_end_value", int'($signed(modified_sample)), 0);

        // Abort mid-interval: three samples, then reset clears everything.
        for (int i = 0; i < 3; i++) push(50 * (i + 1), 1'b0);
        do_start(400, 1'b0);
        for (int i = 0; i < 3; i++) do_step();
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("abort_sample", int'(modified_sample), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_drained", sb.size(), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        interval("after_abort", 80, v6);

        repeat (5) @(posedge clock);
        check("final_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
